// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every input pattern in turn,
// samples the DUT output and tallies mismatches against a latched table.
module tt_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 loop,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   exp_tt,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      stim_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_cnt,
  output logic [N_IN-1:0]      first_fail,
  output logic                 fail_valid
);

  localparam int              NP   = 2**N_IN;
  localparam logic [7:0]      HOLD = 8'(SETTLE);
  localparam logic [N_IN:0]   LAST = (N_IN+1)'(NP-1);
  localparam logic [N_IN:0]   ONE  = (N_IN+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_DONE
  } state_t;

  state_t          state;
  logic [N_IN:0]   idx;
  logic [7:0]      cnt;
  logic [NP-1:0]   exp_q;
  logic            loop_q;

  logic            miss;
  logic [N_IN:0]   idx_inc;
  logic [N_IN:0]   err_inc;

  assign miss    = dut_y != exp_q[idx[N_IN-1:0]];
  assign idx_inc = idx + ONE;
  assign err_inc = err_cnt + ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      exp_q      <= '0;
      loop_q     <= 1'b0;
      stim_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state      <= S_APPLY;
            idx        <= '0;
            cnt        <= HOLD;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
            exp_q      <= exp_tt;
            loop_q     <= loop;
            busy       <= 1'b1;
            stim_out   <= '0;
          end
        end
        S_APPLY: begin
          if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            stim_out <= '0;
            pass     <= 1'b0;
          end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            if (miss) begin
              err_cnt <= err_inc;
              if (!fail_valid) begin
                first_fail <= idx[N_IN-1:0];
                fail_valid <= 1'b1;
              end
            end
            // last pattern: stim_out stays put, no wrap
            if (idx == LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= !miss && (err_cnt == '0);
            end else begin
              idx      <= idx_inc;
              stim_out <= idx_inc[N_IN-1:0];
              cnt      <= HOLD;
            end
          end
        end
        S_DONE: begin
          if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            stim_out <= '0;
            pass     <= 1'b0;
          end else if (loop_q) begin
            state      <= S_APPLY;
            idx        <= '0;
            cnt        <= HOLD;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
            stim_out   <= '0;
          end else begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            stim_out <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker with a table-driven DUT model.
module tb_tt_sweep_checker;

  logic        clk = 1'b0;
  logic        rst_n, start, loop, abort;
  logic [15:0] exp_tt, model;
  logic        dut_y;
  logic [3:0]  stim_out, first_fail;
  logic        busy, done, pass, fail_valid;
  logic [4:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] err;
    logic [3:0] ff;
    logic       fv;
    logic       pass;
    int         edge_n;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign dut_y = model[stim_out];

  tt_sweep_checker #(.N_IN(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .loop(loop),
    .abort(abort), .exp_tt(exp_tt), .dut_y(dut_y),
    .stim_out(stim_out), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail(first_fail),
    .fail_valid(fail_valid)
  );

  function automatic exp_t predict(logic [15:0] m, logic [15:0] e,
                                   int edge_n);
    exp_t x;
    x.err = '0; x.ff = '0; x.fv = 1'b0; x.edge_n = edge_n;
    for (int k = 0; k < 16; k++) begin
      if (m[k] != e[k]) begin
        if (!x.fv) x.ff = 4'(k);
        x.fv = 1'b1;
        x.err = x.err + 5'd1;
      end
    end
    x.pass = (x.err == 5'd0);
    return x;
  endfunction

  // Starts a sweep (edge 0 = first edge with start high) and counts
  // edges until done; start_at re-pulses start mid-sweep.
  task automatic run_sweep(input logic [15:0] m, input logic [15:0] e,
                           input int start_at, output int done_edge,
                           output int stim_bad, output int busy_bad);
    logic [3:0] es;
    model = m; exp_tt = e;
    sb.push_back(predict(m, e, 32));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    done_edge = -1; stim_bad = 0; busy_bad = 0;
    for (int n = 1; n <= 200; n++) begin
      start = (n == start_at);
      @(negedge clk);
      es = (n / 2 > 15) ? 4'd15 : 4'(n / 2);
      if (stim_out !== es) stim_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        done_edge = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; loop = 0; abort = 0;
    exp_tt = 16'hA5C3; model = 16'hA5C3;
    repeat (2) @(negedge clk);
    checks++;
    if ({stim_out, busy, done, pass, err_cnt, first_fail, fail_valid}
        !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {stim_out, busy, done, pass, err_cnt, first_fail,
                fail_valid});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep(input string nm, input logic [15:0] m,
                            input logic [15:0] e);
    int de, sbad, bbad;
    exp_t x;
    run_sweep(m, e, -1, de, sbad, bbad);
    x = sb.pop_front();
    checks++;
    if (de !== x.edge_n) begin
      failures++;
      $display("FAIL %s done_edge got=%0d want=%0d", nm, de, x.edge_n);
    end
    checks++;
    if (sbad !== 0 || bbad !== 0) begin
      failures++;
      $display("FAIL %s stim_busy got=%0d/%0d want=0/0", nm, sbad, bbad);
    end
    checks++;
    if ({err_cnt, first_fail, fail_valid, pass} !==
        {x.err, x.ff, x.fv, x.pass}) begin
      failures++;
      $display("FAIL %s result got=err%0d ff%0d fv%0d p%0d want=err%0d ff%0d fv%0d p%0d",
               nm, err_cnt, first_fail, fail_valid, pass,
               x.err, x.ff, x.fv, x.pass);
    end
    @(negedge clk);
    checks++;
    if ({busy, done, stim_out} !== '0) begin
      failures++;
      $display("FAIL %s idle_after got=%h want=0", nm,
               {busy, done, stim_out});
    end
  endtask

  task automatic test_abort;
    logic [4:0] perr;
    int seen, dn;
    model = 16'hA5C3 ^ 16'h0208; exp_tt = 16'hA5C3;
    perr = '0;
    for (int k = 0; k < 5; k++)
      if (model[k] != exp_tt[k]) perr = perr + 5'd1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (stim_out === 4'd5) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (seen !== 1) begin
      failures++;
      $display("FAIL abort_reach5 got=%0d want=1", seen);
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++;
    if ({busy, stim_out, done, pass} !== '0) begin
      failures++;
      $display("FAIL abort_idle got=%h want=0",
               {busy, stim_out, done, pass});
    end
    checks++;
    if ({err_cnt, first_fail, fail_valid} !== {perr, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL abort_partial got=err%0d ff%0d fv%0d want=err%0d ff3 fv1",
               err_cnt, first_fail, fail_valid, perr);
    end
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    checks++;
    if (dn !== 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d want=0", dn);
    end
    test_sweep("after_abort", 16'hA5C3, 16'hA5C3);
  endtask

  task automatic test_loop;
    int n, dn;
    exp_t x;
    model = 16'h3C96; exp_tt = 16'h3C96; loop = 1'b1;
    sb.push_back(predict(model, exp_tt, 32));
    sb.push_back(predict(model, exp_tt, 65));
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin start = 1'b0; loop = 1'b0; end
    dn = 0;
    for (n = 1; n <= 300 && dn < 2; n++) begin
      if (n == 10) exp_tt = ~exp_tt;
      @(negedge clk);
      if (done === 1'b1) begin
        dn++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL loop_sb got=empty want=entry");
        end else begin
          x = sb.pop_front();
          checks++;
          if (n !== x.edge_n || pass !== x.pass) begin
            failures++;
            $display("FAIL loop_done got=e%0d p%0d want=e%0d p%0d",
                     n, pass, x.edge_n, x.pass);
          end
        end
      end
    end
    checks++;
    if (dn !== 2) begin
      failures++;
      $display("FAIL loop_count got=%0d want=2", dn);
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++;
    if ({busy, done, stim_out} !== '0) begin
      failures++;
      $display("FAIL loop_abort got=%h want=0", {busy, done, stim_out});
    end
    exp_tt = 16'hA5C3;
  endtask

  task automatic test_back_to_back;
    int de, sbad, bbad;
    exp_t x;
    run_sweep(16'hA5C3, 16'hA5C3, 5, de, sbad, bbad);
    x = sb.pop_front();
    checks++;
    if (de !== x.edge_n || sbad !== 0 || pass !== x.pass) begin
      failures++;
      $display("FAIL busy_start got=e%0d bad%0d p%0d want=e%0d bad0 p%0d",
               de, sbad, pass, x.edge_n, x.pass);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    model = 16'hA5C3; exp_tt = 16'hA5C3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    checks++;
    if ({stim_out, busy, done, pass, err_cnt, first_fail, fail_valid}
        !== '0) begin
      failures++;
      $display("FAIL reset_mid got=%h want=0",
               {stim_out, busy, done, pass, err_cnt, first_fail,
                fail_valid});
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_abort_idle got=%0d want=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_sweep("match", 16'hA5C3, 16'hA5C3);
    test_sweep("two_err", 16'hA5C3 ^ 16'h0208, 16'hA5C3);
    test_sweep("all_wrong", 16'hA5C3, ~16'hA5C3);
    test_abort();
    test_loop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
